// File: rtl/imm_materializer_if.sv
// Request/instruction-stream bundle for imm_materializer: constant + Rd in, instruction words out.
interface imm_materializer_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_value;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_last;
  logic        busy;

  modport master (
    output in_valid, in_value, in_rd, out_ready,
    input  in_ready, out_valid, out_instr, out_last, busy
  );

  modport slave (
    input  in_valid, in_value, in_rd, out_ready,
    output in_ready, out_valid, out_instr, out_last, busy
  );
endinterface

// File: rtl/imm_materializer.sv
// Turns a 64-bit constant + Rd into the shortest MOVZ/MOVK word sequence (hw[22:21], imm16[20:5], Rd[4:0]).
// Define IMM_MATERIALIZER_MOVN_EN to start mostly-ones constants with MOVN instead of MOVZ.
module imm_materializer #(
  parameter int REG_WIDTH = 64
) (
  input logic clk,
  input logic reset,
  imm_materializer_if.slave bus
);

  localparam int NUM_HW = REG_WIDTH / 16;
  localparam logic [31:0] MOVZ_BASE = (REG_WIDTH == 64) ? 32'hD280_0000 : 32'h5280_0000;
  localparam logic [31:0] MOVK_BASE = (REG_WIDTH == 64) ? 32'hF280_0000 : 32'h7280_0000;
  localparam logic [31:0] MOVN_BASE = (REG_WIDTH == 64) ? 32'h9280_0000 : 32'h1280_0000;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t      state_reg;
  logic [63:0] value_reg;
  logic [4:0]  rd_reg;
  logic [3:0]  pend_reg;
  logic        first_reg;
  logic        inv_reg;
  logic        in_ready_reg;
  logic        out_valid_reg;
  logic [31:0] out_instr_reg;
  logic        out_last_reg;
  logic        busy_reg;

  logic [3:0] hw_active;
  logic [3:0] hw_zero;
  logic [3:0] pend_raw;
  logic [3:0] accept_pend;
  logic [3:0] pend_after;
  logic       use_inv;

  function automatic logic [1:0] low_idx(input logic [3:0] p);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (p[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic is_single(input logic [3:0] p);
    return (p != 4'b0000) && ((p & (p - 4'd1)) == 4'b0000);
  endfunction

  // First word of an inverted sequence is MOVN and carries the complemented halfword.
  function automatic logic [31:0] encode(input logic first, input logic inv,
                                         input logic [3:0] p, input logic [63:0] val,
                                         input logic [4:0] rd);
    logic [1:0]  idx;
    logic [15:0] imm;
    logic [31:0] base;
    idx  = low_idx(p);
    imm  = val[{idx, 4'b0000} +: 16];
    base = MOVK_BASE;
    if (first) begin
      base = inv ? MOVN_BASE : MOVZ_BASE;
      if (inv) imm = ~imm;
    end
    return base | {9'b0, idx, 21'b0} | {11'b0, imm, 5'b0} | {27'b0, rd};
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_hw
      assign hw_active[gi] = (gi < NUM_HW);
      assign hw_zero[gi]   = (bus.in_value[gi*16 +: 16] == 16'h0000);
    end
  endgenerate

`ifdef IMM_MATERIALIZER_MOVN_EN
  logic [3:0] hw_ones;
  logic [2:0] count_ones;
  logic [2:0] count_zero;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  generate
    for (gi = 0; gi < 4; gi++) begin : g_ones
      assign hw_ones[gi] = (bus.in_value[gi*16 +: 16] == 16'hFFFF);
    end
  endgenerate

  assign count_ones = popcount4(hw_active & hw_ones);
  assign count_zero = popcount4(hw_active & hw_zero);
  assign use_inv    = (count_ones > count_zero);
  assign pend_raw   = use_inv ? (hw_active & ~hw_ones) : (hw_active & ~hw_zero);
`else
  assign use_inv  = 1'b0;
  assign pend_raw = hw_active & ~hw_zero;
`endif

  assign accept_pend = (pend_raw == 4'b0000) ? 4'b0001 : pend_raw;
  assign pend_after  = pend_reg & (pend_reg - 4'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      value_reg     <= '0;
      rd_reg        <= '0;
      pend_reg      <= '0;
      first_reg     <= 1'b0;
      inv_reg       <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      out_instr_reg <= '0;
      out_last_reg  <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            state_reg     <= EMIT;
            value_reg     <= bus.in_value;
            rd_reg        <= bus.in_rd;
            pend_reg      <= accept_pend;
            first_reg     <= 1'b1;
            inv_reg       <= use_inv;
            in_ready_reg  <= 1'b0;
            busy_reg      <= 1'b1;
            out_valid_reg <= 1'b1;
            out_instr_reg <= encode(1'b1, use_inv, accept_pend, bus.in_value, bus.in_rd);
            out_last_reg  <= is_single(accept_pend);
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            pend_reg  <= pend_after;
            first_reg <= 1'b0;
            if (out_last_reg) begin
              state_reg     <= IDLE;
              in_ready_reg  <= 1'b1;
              busy_reg      <= 1'b0;
              out_valid_reg <= 1'b0;
              out_instr_reg <= '0;
              out_last_reg  <= 1'b0;
            end else begin
              out_instr_reg <= encode(1'b0, inv_reg, pend_after, value_reg, rd_reg);
              out_last_reg  <= is_single(pend_after);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_instr = out_instr_reg;
  assign bus.out_last  = out_last_reg;
  assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_imm_materializer.sv
// Directed bench for imm_materializer: 64-bit instance for most steps, 32-bit instance for the sf=0 case.
module tb_imm_materializer;
  logic clk;
  logic reset;
  int   tests;
  int   fails;

  imm_materializer_if bus64 ();
  imm_materializer_if bus32 ();

  imm_materializer #(.REG_WIDTH(64)) dut64 (.clk(clk), .reset(reset), .bus(bus64.slave));
  imm_materializer #(.REG_WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one request for a single cycle, then scramble the inputs to show they are not re-sampled.
  task automatic issue(input logic [63:0] value, input logic [4:0] rd);
    bus64.in_valid = 1'b1;
    bus64.in_value = value;
    bus64.in_rd    = rd;
    @(negedge clk);
    bus64.in_valid = 1'b0;
    bus64.in_value = 64'hA5A5_5A5A_C3C3_3C3C;
    bus64.in_rd    = 5'd31;
  endtask

  // Check the word on offer at this negedge; with out_ready high it transfers at the next posedge.
  task automatic expect_word(input string tag, input logic [31:0] instr, input logic last);
    for (int n = 0; n < 10 && !bus64.out_valid; n++) @(negedge clk);
    check({tag, " valid"}, 64'(bus64.out_valid), 64'd1);
    check({tag, " instr"}, 64'(bus64.out_instr), 64'(instr));
    check({tag, " last"},  64'(bus64.out_last),  64'(last));
    $display("[TB] %s instr=%08h last=%0d", tag, bus64.out_instr, bus64.out_last);
    @(negedge clk);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus64.in_valid = 1'b0; bus64.in_value = '0; bus64.in_rd = '0; bus64.out_ready = 1'b1;
    bus32.in_valid = 1'b0; bus32.in_value = '0; bus32.in_rd = '0; bus32.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst in_ready",  64'(bus64.in_ready),  64'd1);
    check("rst out_valid", 64'(bus64.out_valid), 64'd0);
    check("rst out_instr", 64'(bus64.out_instr), 64'd0);
    check("rst out_last",  64'(bus64.out_last),  64'd0);
    check("rst busy",      64'(bus64.busy),      64'd0);
    $display("[TB] reset state checked");

    // 1: two-word sequence
    issue(64'h0000_1234_0000_5678, 5'd3);
    check("c1 busy", 64'(bus64.busy), 64'd1);
    check("c1 in_ready low", 64'(bus64.in_ready), 64'd0);
    expect_word("c1 w0", 32'hD28A_CF03, 1'b0);
    expect_word("c1 w1", 32'hF2C2_4683, 1'b1);
    check("c1 in_ready back", 64'(bus64.in_ready), 64'd1);
    check("c1 out_valid off", 64'(bus64.out_valid), 64'd0);
    check("c1 busy off", 64'(bus64.busy), 64'd0);

    // 2: zero constant still emits one MOVZ
    issue(64'h0, 5'd0);
    expect_word("c2 w0", 32'hD280_0000, 1'b1);
    check("c2 idle", 64'(bus64.in_ready), 64'd1);

    // 3: mostly-ones constant
    issue(64'hFFFF_FFFF_FFFF_FFFE, 5'd1);
`ifdef IMM_MATERIALIZER_MOVN_EN
    expect_word("c3 movn", 32'h9280_0021, 1'b1);
`else
    expect_word("c3 w0", 32'hD29F_FFC1, 1'b0);
    expect_word("c3 w1", 32'hF2BF_FFE1, 1'b0);
    expect_word("c3 w2", 32'hF2DF_FFE1, 1'b0);
    expect_word("c3 w3", 32'hF2FF_FFE1, 1'b1);
`endif
    check("c3 idle", 64'(bus64.in_ready), 64'd1);

    // 4: backpressure holds the first word
    bus64.out_ready = 1'b0;
    issue(64'h0000_1234_0000_5678, 5'd3);
    for (int i = 0; i < 5; i++) begin
      check("c4 hold valid", 64'(bus64.out_valid), 64'd1);
      check("c4 hold instr", 64'(bus64.out_instr), 64'hD28A_CF03);
      check("c4 hold last",  64'(bus64.out_last),  64'd0);
      check("c4 hold ready", 64'(bus64.in_ready),  64'd0);
      @(negedge clk);
    end
    $display("[TB] c4 held 5 cycles");
    bus64.out_ready = 1'b1;
    expect_word("c4 w0", 32'hD28A_CF03, 1'b0);
    expect_word("c4 w1", 32'hF2C2_4683, 1'b1);
    check("c4 idle", 64'(bus64.in_ready), 64'd1);

    // 5: reset mid-sequence, with out_ready still high
    issue(64'h0000_1234_0000_5678, 5'd3);
    expect_word("c5 w0", 32'hD28A_CF03, 1'b0);
    check("c5 pending w1", 64'(bus64.out_instr), 64'hF2C2_4683);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("c5 rst out_valid", 64'(bus64.out_valid), 64'd0);
    check("c5 rst in_ready",  64'(bus64.in_ready),  64'd1);
    check("c5 rst out_instr", 64'(bus64.out_instr), 64'd0);
    check("c5 rst out_last",  64'(bus64.out_last),  64'd0);
    $display("[TB] c5 reset mid-sequence");
    issue(64'h0000_0000_0000_00FF, 5'd2);
    expect_word("c5 new", 32'hD280_1FE2, 1'b1);

    // 6: 32-bit instance ignores the upper word
    bus32.in_valid = 1'b1;
    bus32.in_value = 64'hDEAD_BEEF_0001_0000;
    bus32.in_rd    = 5'd4;
    @(negedge clk);
    bus32.in_valid = 1'b0;
    check("c6 valid", 64'(bus32.out_valid), 64'd1);
    check("c6 instr", 64'(bus32.out_instr), 64'h52A0_0024);
    check("c6 last",  64'(bus32.out_last),  64'd1);
    $display("[TB] c6 instr=%08h last=%0d", bus32.out_instr, bus32.out_last);
    @(negedge clk);
    check("c6 idle", 64'(bus32.in_ready), 64'd1);
    check("c6 valid off", 64'(bus32.out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
